// File: rtl/adder_loader_pkg.sv
// Shared types and widths for the adder operand loader.
package adder_loader_pkg;

    localparam int unsigned OPERAND_W = 3;
    localparam int unsigned STATE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        READY   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser, consecutive-cycle debounce counter and rising-edge one-shot
// for an asynchronous push-button.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_async,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   btn;
    logic                   level;
    logic [CNT_W-1:0]       count;

    assign btn = sync[SYNC_STAGES-1];

    // Accepted level resets high so a button held through reset must be
    // seen low for a full debounce window before it can produce a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b1;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn_async};
            press <= 1'b0;
            if (btn != level) begin
                if (count == LAST) begin
                    level <= btn;
                    count <= '0;
                    press <= btn;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/adder_operand_loader.sv
// Collects two operands from a shared switch bus, one per debounced ENTER
// press, and presents them to the ripple adder with a valid flag.
module adder_operand_loader
    import adder_loader_pkg::*;
#(
    parameter int unsigned WIDTH           = OPERAND_W,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               enter,
    input  logic               clear,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic               operands_valid,
    output logic [STATE_W-1:0] state_out
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] data_sync;
    logic [WIDTH-1:0]                  data_s;
    logic                              press;
    state_t                            state, state_next;
    logic [WIDTH-1:0]                  op_a_next, op_b_next;

    button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clock    (clock),
        .reset    (reset),
        .btn_async(enter),
        .press    (press)
    );

    // Same depth as the button path so the captured value lines up with press.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_sync <= '0;
        end else begin
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
        end
    end

    assign data_s = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WAIT_A;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            state <= state_next;
            op_a  <= op_a_next;
            op_b  <= op_b_next;
        end
    end

    always_comb begin
        state_next = state;
        op_a_next  = op_a;
        op_b_next  = op_b;
        if (clear) begin
            state_next = WAIT_A;
            op_a_next  = '0;
            op_b_next  = '0;
        end else begin
            case (state)
                WAIT_A: if (press) begin
                    op_a_next  = data_s;
                    state_next = WAIT_B;
                end
                WAIT_B: if (press) begin
                    op_b_next  = data_s;
                    state_next = READY;
                end
                READY: if (press) begin
                    op_a_next  = data_s;
                    op_b_next  = '0;
                    state_next = WAIT_B;
                end
                default: state_next = WAIT_A;
            endcase
        end
    end

    always_comb begin
        operands_valid = (state == READY);
        state_out      = state;
    end

endmodule
